// File: rtl/wfifo_level_tracker_pkg.sv
// Shared FIFO package: watermark state encoding, FIFO depth derivation and
// gray-to-binary pointer conversion used by the write-domain level tracker
// (and by its read-domain counterpart).
package wfifo_level_tracker_pkg;

  // Watermark states; LOW must encode as zero so a cleared register is LOW.
  typedef enum logic [1:0] {
    WM_LOW  = 2'd0,
    WM_HIGH = 2'd1,
    WM_FULL = 2'd2
  } wm_state_e;

  // Widest pointer the gray converter handles.
  localparam int unsigned GRAY_MAX_W = 16;

  // Number of FIFO entries addressed by a pointer of ptr_width bits.
  function automatic int unsigned fifo_depth(input int unsigned ptr_width);
    return 32'd1 << ptr_width;
  endfunction

  // Gray to binary: bit i is the XOR of all gray bits from the MSB down to i.
  // Narrower pointers are zero-extended by the caller; leading zeros do not
  // change the XOR, so the low bits of the result are exact.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wfifo_level_tracker_gray_sync.sv
// gray_sync: two-flop synchronizer for a gray-coded pointer crossing into the
// clk domain. Only one bit changes per pointer step, so any sampled value is
// either the old or the new pointer.
// Ports:
//   clk   - destination-domain clock
//   rst_n - asynchronous active-low reset, clears both stages
//   d     - gray pointer from the source domain (asynchronous)
//   q     - synchronized pointer (second stage)
module gray_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1_r;
  logic [WIDTH-1:0] stage2_r;

  // Two synchronizer stages; a change on d reaches q at the 2nd rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_r <= '0;
      stage2_r <= '0;
    end else begin
      stage1_r <= d;
      stage2_r <= stage1_r;
    end
  end

  assign q = stage2_r;

endmodule

// File: rtl/wfifo_level_tracker.sv
// wfifo_level_tracker: write-domain fill-level tracker for an async FIFO.
// Synchronizes the gray read pointer, computes a registered fill level,
// runs a hysteretic almost-full watermark FSM, and keeps overflow and
// pointer-consistency status.
// Ports:
//   wclk, wrst_n  - write clock, asynchronous active-low reset
//   g_rptr        - gray read pointer from the read domain (asynchronous)
//   b_wptr        - binary write pointer
//   w_en, full    - write request and full flag; both high = rejected write
//   clr_ovf       - synchronous clear of overflow and ovf_count
//   g_rptr_sync   - synchronized gray read pointer
//   wr_level      - registered fill level (0..DEPTH)
//   almost_full   - watermark flag, set at AF_HI, cleared at AF_LO
//   overflow      - sticky rejected-write flag
//   ovf_count     - saturating rejected-write count
//   ptr_err       - sticky flag, level exceeded DEPTH
module wfifo_level_tracker
  import wfifo_level_tracker_pkg::*;
#(
  parameter int PTR_WIDTH = 3,
  parameter int AF_HI     = 6,
  parameter int AF_LO     = 4
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic [PTR_WIDTH:0] g_rptr,
  input  logic [PTR_WIDTH:0] b_wptr,
  input  logic               w_en,
  input  logic               full,
  input  logic               clr_ovf,
  output logic [PTR_WIDTH:0] g_rptr_sync,
  output logic [PTR_WIDTH:0] wr_level,
  output logic               almost_full,
  output logic               overflow,
  output logic [7:0]         ovf_count,
  output logic               ptr_err
);

  localparam int unsigned DEPTH = fifo_depth(PTR_WIDTH);
  localparam int          LW    = PTR_WIDTH + 1;

  localparam logic [PTR_WIDTH:0] DEPTH_L = LW'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_HI_L = LW'(AF_HI);
  localparam logic [PTR_WIDTH:0] AF_LO_L = LW'(AF_LO);

  // Refuse to build with thresholds that make the hysteresis meaningless.
  if (!(AF_LO < AF_HI && AF_HI <= int'(DEPTH))) begin : g_bad_thresholds
    $error("wfifo_level_tracker: need AF_LO < AF_HI <= DEPTH");
  end
  if (LW > int'(GRAY_MAX_W)) begin : g_bad_width
    $error("wfifo_level_tracker: PTR_WIDTH too wide for gray2bin");
  end

  logic [PTR_WIDTH:0] g_rptr_sync_s;
  logic [PTR_WIDTH:0] b_rptr_s;
  logic [PTR_WIDTH:0] wr_level_r;
  wm_state_e          state_r;
  logic               almost_full_r;
  logic               overflow_r;
  logic [7:0]         ovf_count_r;
  logic               ptr_err_r;
  logic               reject_s;

  gray_sync #(
    .WIDTH (LW)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (g_rptr),
    .q     (g_rptr_sync_s)
  );

  assign b_rptr_s = LW'(gray2bin(GRAY_MAX_W'(g_rptr_sync_s)));
  assign reject_s = w_en & full;

  // Fill level; the subtraction wraps modulo 2**LW, absorbing pointer wrap.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wr_level_r <= '0;
    end else begin
      wr_level_r <= b_wptr - b_rptr_s;
    end
  end

  // Watermark FSM; almost_full is registered with the state so it always
  // equals (state != LOW).
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r       <= WM_LOW;
      almost_full_r <= 1'b0;
    end else if (wr_level_r == DEPTH_L) begin
      state_r       <= WM_FULL;
      almost_full_r <= 1'b1;
    end else if (wr_level_r <= AF_LO_L) begin
      state_r       <= WM_LOW;
      almost_full_r <= 1'b0;
    end else if (state_r == WM_LOW && wr_level_r >= AF_HI_L) begin
      state_r       <= WM_HIGH;
      almost_full_r <= 1'b1;
    end else if (state_r == WM_FULL && wr_level_r < DEPTH_L) begin
      // Level is already known to be above AF_LO here.
      state_r       <= WM_HIGH;
      almost_full_r <= 1'b1;
    end else begin
      state_r       <= state_r;
      almost_full_r <= almost_full_r;
    end
  end

  // Overflow status; a rejected write in the clearing cycle is kept as the
  // first event of the new count.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      overflow_r  <= 1'b0;
      ovf_count_r <= 8'd0;
    end else if (clr_ovf) begin
      overflow_r  <= reject_s;
      ovf_count_r <= reject_s ? 8'd1 : 8'd0;
    end else if (reject_s) begin
      overflow_r  <= 1'b1;
      ovf_count_r <= (ovf_count_r == 8'hFF) ? 8'hFF : ovf_count_r + 8'd1;
    end else begin
      overflow_r  <= overflow_r;
      ovf_count_r <= ovf_count_r;
    end
  end

  // Sticky pointer-consistency error; only reset clears it.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      ptr_err_r <= 1'b0;
    end else if (wr_level_r > DEPTH_L) begin
      ptr_err_r <= 1'b1;
    end else begin
      ptr_err_r <= ptr_err_r;
    end
  end

  assign g_rptr_sync = g_rptr_sync_s;
  assign wr_level    = wr_level_r;
  assign almost_full = almost_full_r;
  assign overflow    = overflow_r;
  assign ovf_count   = ovf_count_r;
  assign ptr_err     = ptr_err_r;

endmodule

// File: doc/wfifo_level_tracker.md
WFIFO_LEVEL_TRACKER -- requirements
Module: wfifo_level_tracker

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 3: address width; DEPTH = 2**PTR_WIDTH entries.
REQ-002 SHALL have parameter AF_HI, default 6: almost-full entry threshold, in entries.
REQ-003 SHALL have parameter AF_LO, default 4: almost-full exit threshold, in entries.
REQ-004 SHALL have port wclk  input  1  write-domain clock.
REQ-005 SHALL have port wrst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port g_rptr  input  PTR_WIDTH+1  gray read pointer, driven from the read clock domain (asynchronous).
REQ-007 SHALL have port b_wptr  input  PTR_WIDTH+1  binary write pointer from the write pointer handler.
REQ-008 SHALL have port w_en  input  1  write request presented to the FIFO.
REQ-009 SHALL have port full  input  1  full flag from the write pointer handler.
REQ-010 SHALL have port clr_ovf  input  1  synchronous clear of the overflow status.
REQ-011 SHALL have port g_rptr_sync  output  PTR_WIDTH+1  g_rptr after the 2-stage synchronizer.
REQ-012 SHALL have port wr_level  output  PTR_WIDTH+1  registered fill level, 0..DEPTH.
REQ-013 SHALL have port almost_full  output  1  hysteretic watermark flag.
REQ-014 SHALL have port overflow  output  1  sticky flag: a write was attempted while full.
REQ-015 SHALL have port ovf_count  output  8  saturating count of rejected writes.
REQ-016 SHALL have port ptr_err  output  1  sticky flag: inconsistent pointers (level > DEPTH).

Function
REQ-017 SHALL pass g_rptr through two wclk flops; g_rptr_sync is the second stage, so a g_rptr change appears on g_rptr_sync at the 2nd rising edge.
REQ-018 SHALL convert g_rptr_sync to binary b_rptr_s (bit i = XOR of bits PTR_WIDTH down to i), combinationally.
REQ-019 SHALL register wr_level <= (b_wptr - b_rptr_s) mod 2**(PTR_WIDTH+1) every cycle: 1-cycle latency from b_wptr/g_rptr_sync; wrap of either pointer is handled by the modulo.
REQ-020 SHALL run a watermark FSM with states LOW, HIGH, FULL, updated every cycle from the registered wr_level.
REQ-021 SHALL apply these FSM transitions, evaluated in priority order: wr_level==DEPTH -> FULL; wr_level<=AF_LO -> LOW; LOW with wr_level>=AF_HI -> HIGH; otherwise hold, except that FULL with AF_LO<wr_level<DEPTH -> HIGH.
REQ-022 SHALL drive almost_full = (state != LOW), decoded from the state register, so it lags wr_level by 1 cycle.
REQ-023 SHALL, on each edge with w_en && full: set overflow=1 and increment ovf_count, saturating at 255.
REQ-024 SHALL, on clr_ovf, clear overflow and ovf_count; if a rejected write occurs in the same cycle, overflow=1 and ovf_count=1.
REQ-025 SHALL set ptr_err=1 when registered wr_level > DEPTH; it stays set until reset and is unaffected by clr_ovf.
REQ-026 SHALL elaborate only when AF_LO < AF_HI <= DEPTH; otherwise elaboration SHALL fail.

Reset
REQ-027 SHALL, while wrst_n=0, asynchronously clear both synchronizer stages, wr_level, state (to LOW), overflow, ovf_count and ptr_err to 0.
REQ-028 SHALL release from reset synchronously, with the first update on the first wclk edge after deassertion; a reset mid-operation discards all history, including sticky flags.

Structure
REQ-029 SHALL take from the shared fifo package: the watermark state enum (LOW/HIGH/FULL), the gray-to-binary function and the DEPTH derivation.
REQ-030 SHALL implement the 2-flop synchronizer as sub-module gray_sync (parameter WIDTH), reusable for the read-domain counterpart.

Verification (PTR_WIDTH=3, DEPTH=8, AF_HI=6, AF_LO=4)
REQ-031 SHALL cover: assert wrst_n=0 mid-traffic -> all outputs 0 immediately, state LOW.
REQ-032 SHALL cover: g_rptr=0, b_wptr 0->6 -> wr_level=6 one edge later, almost_full=1 one edge after that; g_rptr changes are seen on g_rptr_sync exactly 2 edges later.
REQ-033 SHALL cover hysteresis from level 6: level 5 -> almost_full stays 1; level 4 -> almost_full=0; level 8 -> FULL; then level 7 -> HIGH, almost_full=1.
REQ-034 SHALL cover wrap: b_wptr=4'b0010, g_rptr=4'b1010 (binary 12) -> wr_level=6, ptr_err=0.
REQ-035 SHALL cover overflow: full=1, w_en=1 for 3 cycles -> overflow=1, ovf_count=3; clr_ovf with a rejected write in the same cycle -> ovf_count=1; 300 rejected writes -> ovf_count=255.
REQ-036 SHALL cover pointer error: b_wptr=9, g_rptr=0 -> wr_level=9, ptr_err=1, and ptr_err stays 1 after clr_ovf.
